// File: rtl/ocr_disp_pkg.sv
// Shared constants for the OCR result display: digit codes and FSM state encoding.
package ocr_disp_pkg;

    localparam logic [3:0] DIG_BLANK  = 4'hF;
    localparam logic [3:0] DIG_ALL_ON = 4'd8;
    localparam logic [3:0] DIG_MAX    = 4'd9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_SHOW = 2'd2;

    function automatic logic digit_legal(input logic [3:0] d);
        return (d <= DIG_MAX);
    endfunction

endpackage

// File: rtl/ocr_result_display_if.sv
// Classifier-to-display bus: result/start pulses in, decoder codes and status out.
interface ocr_result_display_if;
    logic       start;
    logic       result_valid;
    logic [3:0] result_digit;
    logic [3:0] num;
    logic [3:0] num_prev;
    logic       busy;
    logic       err;

    modport master (output start, result_valid, result_digit,
                    input  num, num_prev, busy, err);
    modport slave  (input  start, result_valid, result_digit,
                    output num, num_prev, busy, err);
endinterface

// File: rtl/ocr_result_display_tick_timer.sv
// Up-counter with synchronous clear and terminal-count detect; wraps to zero at limit-1.
module ocr_tick_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);
    logic [CNT_W-1:0] cnt_r;

    assign tc = en & (cnt_r == (limit - CNT_W'(1)));

    // Counter: clear wins, then wrap on terminal count, else advance while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || tc) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/ocr_result_display.sv
// Latches classifier digits for the current/previous 7-segment decoders, blinks while
// inference is busy, optionally blanks after a hold time and flags illegal codes.
module ocr_result_display
    import ocr_disp_pkg::*;
#(
    parameter int BLINK_CYCLES = 12_500_000,
    parameter int HOLD_CYCLES  = 0,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ocr_result_display_if.slave  bus
);
    localparam logic [CNT_W-1:0] BLINK_LIM = CNT_W'(BLINK_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_CYCLES);
    localparam logic             HOLD_EN   = (HOLD_CYCLES != 0);

    logic [1:0]       state_r, state_s;
    logic             phase_r, phase_s;
    logic [3:0]       last_good_r, last_good_s;
    logic [3:0]       num_r, num_s;
    logic [3:0]       num_prev_r, num_prev_s;
    logic             err_r, err_s;
    logic             busy_r;
    logic             tmr_clr_s, tmr_en_s, tc_s;
    logic [CNT_W-1:0] tmr_limit_s;

    // One timer serves both blink half-periods and the display hold; start inside BUSY must not clear it.
    always_comb begin
        tmr_clr_s   = bus.result_valid | (bus.start & (state_r != ST_BUSY));
        tmr_en_s    = 1'b0;
        tmr_limit_s = HOLD_LIM;
        if (state_r == ST_BUSY) begin
            tmr_en_s    = 1'b1;
            tmr_limit_s = BLINK_LIM;
        end else if (state_r == ST_SHOW) begin
            tmr_en_s    = HOLD_EN;
            tmr_limit_s = HOLD_LIM;
        end else begin
            tmr_en_s    = 1'b0;
            tmr_limit_s = HOLD_LIM;
        end
    end

    ocr_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .limit (tmr_limit_s),
        .tc    (tc_s)
    );

    // Next-state and next-output logic; result_valid outranks start in every state.
    always_comb begin
        state_s     = state_r;
        phase_s     = phase_r;
        last_good_s = last_good_r;
        num_s       = num_r;
        num_prev_s  = num_prev_r;
        err_s       = err_r;
        if (bus.result_valid) begin
            if (digit_legal(bus.result_digit)) begin
                num_prev_s  = last_good_r;
                last_good_s = bus.result_digit;
                num_s       = bus.result_digit;
                err_s       = 1'b0;
                state_s     = ST_SHOW;
            end else begin
                err_s   = 1'b1;
                num_s   = DIG_BLANK;
                state_s = ST_IDLE;
            end
        end else if (bus.start && (state_r != ST_BUSY)) begin
            state_s = ST_BUSY;
            err_s   = 1'b0;
            phase_s = 1'b1;
            num_s   = DIG_ALL_ON;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    num_s = DIG_BLANK;
                end
                ST_BUSY: begin
                    if (tc_s) begin
                        phase_s = ~phase_r;
                        num_s   = phase_r ? DIG_BLANK : DIG_ALL_ON;
                    end else begin
                        phase_s = phase_r;
                    end
                end
                ST_SHOW: begin
                    if (tc_s) begin
                        state_s = ST_IDLE;
                        num_s   = DIG_BLANK;
                    end else begin
                        num_s = last_good_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    num_s   = DIG_BLANK;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            phase_r     <= 1'b1;
            last_good_r <= DIG_BLANK;
            num_r       <= DIG_BLANK;
            num_prev_r  <= DIG_BLANK;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            last_good_r <= last_good_s;
            num_r       <= num_s;
            num_prev_r  <= num_prev_s;
            err_r       <= err_s;
            busy_r      <= (state_s == ST_BUSY);
        end
    end

    assign bus.num      = num_r;
    assign bus.num_prev = num_prev_r;
    assign bus.busy     = busy_r;
    assign bus.err      = err_r;
endmodule

// File: tb/tb_ocr_result_display.sv
// Drives two display instances (indefinite hold and 6-cycle hold) with directed and random
// pulses, checking every cycle against a mode/age reference model.
module tb_ocr_result_display;
    localparam int BLINK  = 4;
    localparam int HOLD_B = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rv = 1'b0;
    logic [3:0] dig = 4'd0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Reference model: mode 0 idle, 1 busy, 2 show; age = clock edges since entering the mode.
    int         m_mode [2];
    int         m_age  [2];
    logic [3:0] m_last [2];
    logic [3:0] m_prev [2];
    logic       m_err  [2];
    int         hold_of [2] = '{0, HOLD_B};

    ocr_result_display_if if_a ();
    ocr_result_display_if if_b ();

    assign if_a.start        = start;
    assign if_a.result_valid = rv;
    assign if_a.result_digit = dig;
    assign if_b.start        = start;
    assign if_b.result_valid = rv;
    assign if_b.result_digit = dig;

    ocr_result_display #(.BLINK_CYCLES(BLINK), .HOLD_CYCLES(0), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a));
    ocr_result_display #(.BLINK_CYCLES(BLINK), .HOLD_CYCLES(HOLD_B), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_age[k] = 0; m_last[k] = 4'hF; m_prev[k] = 4'hF; m_err[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(int k, logic s, logic r, logic [3:0] d);
        if (r) begin
            if (d <= 4'd9) begin
                m_prev[k] = m_last[k]; m_last[k] = d; m_mode[k] = 2; m_age[k] = 0; m_err[k] = 1'b0;
            end else begin
                m_err[k] = 1'b1; m_mode[k] = 0; m_age[k] = 0;
            end
        end else if (s && m_mode[k] != 1) begin
            m_mode[k] = 1; m_age[k] = 0; m_err[k] = 1'b0;
        end else begin
            m_age[k]++;
            if (m_mode[k] == 2 && hold_of[k] != 0 && m_age[k] >= hold_of[k]) m_mode[k] = 0;
        end
    endfunction

    function automatic logic [3:0] exp_num(int k);
        if (m_mode[k] == 1) return ((m_age[k] / BLINK) % 2 == 0) ? 4'd8 : 4'hF;
        else if (m_mode[k] == 2) return m_last[k];
        else return 4'hF;
    endfunction

    task automatic check_model();
        logic [3:0] n, p;
        logic       b, e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                n = if_a.num; p = if_a.num_prev; b = if_a.busy; e = if_a.err;
            end else begin
                n = if_b.num; p = if_b.num_prev; b = if_b.busy; e = if_b.err;
            end
            check_eq($sformatf("num%0d", k),  32'(n), 32'(exp_num(k)));
            check_eq($sformatf("prev%0d", k), 32'(p), 32'(m_prev[k]));
            check_eq($sformatf("busy%0d", k), 32'(b), 32'(m_mode[k] == 1));
            check_eq($sformatf("err%0d", k),  32'(e), 32'(m_err[k]));
        end
    endtask

    // One clock: present pulses, let both DUTs and the model take the edge, check mid-cycle.
    task automatic step(input logic s, input logic r, input logic [3:0] d);
        start = s; rv = r; dig = d;
        @(posedge clk);
        model_step(0, s, r, d);
        model_step(1, s, r, d);
        @(negedge clk);
        start = 1'b0; rv = 1'b0;
        check_model();
    endtask

    initial begin
        int rr;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0);
        check_eq("rst_num", 32'(if_a.num), 32'h0000000F);
        check_eq("rst_prev", 32'(if_a.num_prev), 32'h0000000F);
        check_eq("rst_busy", 32'(if_a.busy), 32'h00000000);
        check_eq("rst_err", 32'(if_a.err), 32'h00000000);

        step(1'b1, 1'b0, 4'd0);
        check_eq("busy_on", 32'(if_a.busy), 32'h00000001);
        check_eq("blink_first", 32'(if_a.num), 32'h00000008);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 4'd0);
            check_eq("blink_seq", 32'(if_a.num), ((i / 4) % 2 == 0) ? 32'h8 : 32'hF);
            check_eq("blink_prev", 32'(if_a.num_prev), 32'hF);
        end

        step(1'b0, 1'b1, 4'd7);
        check_eq("show7_num", 32'(if_a.num), 32'h7);
        check_eq("show7_prev", 32'(if_a.num_prev), 32'hF);
        check_eq("show7_busy", 32'(if_a.busy), 32'h0);
        step(1'b1, 1'b1, 4'd3);
        check_eq("both_num", 32'(if_a.num), 32'h3);
        check_eq("both_prev", 32'(if_a.num_prev), 32'h7);
        check_eq("both_busy", 32'(if_a.busy), 32'h0);
        step(1'b0, 1'b1, 4'd12);
        check_eq("bad_err", 32'(if_a.err), 32'h1);
        check_eq("bad_num", 32'(if_a.num), 32'hF);
        check_eq("bad_prev", 32'(if_a.num_prev), 32'h7);
        step(1'b0, 1'b1, 4'd5);
        check_eq("good_err", 32'(if_a.err), 32'h0);
        check_eq("good_num", 32'(if_a.num), 32'h5);
        check_eq("good_prev", 32'(if_a.num_prev), 32'h3);

        step(1'b0, 1'b1, 4'd2);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 1'b0, 4'd0);
            check_eq("hold_num", 32'(if_b.num), (i < HOLD_B) ? 32'h2 : 32'hF);
            check_eq("hold_prev", 32'(if_b.num_prev), 32'h5);
            check_eq("nohold_num", 32'(if_a.num), 32'h2);
        end
        step(1'b0, 1'b1, 4'd2);
        repeat (HOLD_B - 1) step(1'b0, 1'b0, 4'd0);
        step(1'b0, 1'b1, 4'd4);
        check_eq("tc_win_num", 32'(if_b.num), 32'h4);
        for (int i = 1; i <= HOLD_B; i++) begin
            step(1'b0, 1'b0, 4'd0);
            check_eq("rehold_num", 32'(if_b.num), (i < HOLD_B) ? 32'h4 : 32'hF);
        end

        for (int i = 0; i < 3000; i++) begin
            rr = $urandom_range(0, 99);
            step(rr >= 5 && rr < 14, rr < 9, 4'($urandom_range(0, 15)));
        end

        step(1'b1, 1'b0, 4'd0);
        step(1'b0, 1'b0, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_num", 32'(if_b.num), 32'hF);
        check_eq("arst_prev", 32'(if_b.num_prev), 32'hF);
        check_eq("arst_busy", 32'(if_b.busy), 32'h0);
        check_eq("arst_err", 32'(if_a.err), 32'h0);
        check_eq("arst_num_a", 32'(if_a.num), 32'hF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 4'd0);
        check_eq("post_rst_num", 32'(if_a.num), 32'h8);
        check_eq("post_rst_busy", 32'(if_b.busy), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ocr_result_display.md
Name: ocr_result_display

Overview:
- Sits directly upstream of the 7-segment digit decoder.
- Receives the digit produced by the OCR classifier and latches it.
- Generates the 4-bit digit codes for two decoders: the current result and the previous result.
- While inference runs, it blinks an all-segments-lit busy indication; it blanks the display after a hold timeout and flags out-of-range classifier codes.

Parameters:
- BLINK_CYCLES, 12_500_000, number of clk cycles per blink half-period in BUSY (4 Hz toggle at 50 MHz); must be ≥1.
- HOLD_CYCLES, 0, number of cycles a result stays displayed before blanking; 0 = hold indefinitely.
- CNT_W, 32, width of the internal timer; must hold max(BLINK_CYCLES, HOLD_CYCLES).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse: classifier inference has begun.
- result_valid  input  1  single-cycle pulse: result_digit is valid.
- result_digit  input  4  classified digit; legal range 0..9.
- num  output  4  code for the current-result decoder; 4'hF = blank.
- num_prev  output  4  code for the previous-result decoder; 4'hF = blank.
- busy  output  1  high while in BUSY.
- err  output  1  sticky flag: the last accepted result was out of range.

Behaviour:
- Reset values:
  - state = IDLE, num = 4'hF, num_prev = 4'hF, busy = 0, err = 0.
  - Timer = 0, blink phase = 1, last-good digit register = 4'hF.
  - Reset is asynchronous and may occur mid-BUSY or mid-SHOW; the block returns to the reset values immediately.
- All outputs are registered. An event sampled at edge N is visible on the outputs after edge N.
- States:
  - IDLE: num = 4'hF.
  - BUSY: num alternates between 4'd8 (all segments on) and 4'hF.
  - SHOW: num = latched digit.
- Priority in every state: result_valid > start.
  - When both are asserted in the same cycle, start is ignored.
- Accepted result with result_digit ≤ 9 (any state):
  - num_prev ← last-good digit; last-good ← result_digit; num ← result_digit.
  - err ← 0; go to SHOW; timer ← 0.
- Accepted result with result_digit ≥ 10 (any state):
  - err ← 1; num ← 4'hF; num_prev and last-good unchanged; go to IDLE.
- start (without result_valid):
  - From IDLE or SHOW: go to BUSY; err ← 0; timer ← 0; phase ← 1, so num = 4'd8 on the next cycle.
  - In BUSY: ignored; the blink does not restart.
- BUSY blink:
  - The timer counts 0..BLINK_CYCLES−1. At the terminal count, phase toggles and the timer wraps to 0.
  - num = phase ? 4'd8 : 4'hF.
  - num_prev holds its value throughout BUSY.
- SHOW hold:
  - If HOLD_CYCLES = 0: stay in SHOW until start or result_valid.
  - Otherwise: the timer counts 0..HOLD_CYCLES−1. At the terminal count, go to IDLE and set num ← 4'hF; num_prev is retained.
  - If result_valid arrives on the terminal-count cycle, it wins: the new digit is shown and the timer restarts.
- busy = 1 exactly when state = BUSY.
- No result timeout in BUSY: the block blinks until result_valid arrives or reset.

Decomposition:
- Package ocr_disp_pkg contains:
  - DIG_BLANK = 4'hF, DIG_ALL_ON = 4'd8, DIG_MAX = 4'd9.
  - State encoding: IDLE = 2'd0, BUSY = 2'd1, SHOW = 2'd2.
- One sub-module, ocr_tick_timer: a CNT_W-bit up-counter with clear and terminal-count compare.
  - Inputs: clr, en, limit. Output: tc.
  - Reused for both the blink timing and the hold timing.
- The digit decoders are instantiated by the parent and are not part of this block.

Test Plan:
- Reset, then idle 10 cycles → num = F, num_prev = F, busy = 0, err = 0.
- BLINK_CYCLES = 4: start pulse → busy = 1; num = 8 for 4 cycles, F for 4 cycles, 8 again; num_prev = F throughout.
- In BUSY, result_valid with digit 7 → next cycle: num = 7, num_prev = F, busy = 0. Then start plus result_valid with digit 3 in the same cycle → num = 3, num_prev = 7, busy stays 0.
- result_valid with digit 12 while in SHOW with num = 3 → err = 1, num = F, num_prev = 7 (unchanged). Then result_valid with digit 5 → err = 0, num = 5, num_prev = 3.
- HOLD_CYCLES = 6: result_valid with digit 2 → num = 2 for exactly 6 cycles, then F, with num_prev retained. Second run: result_valid with digit 4 on the terminal-count cycle → num = 4 and the hold restarts.
- Assert rst_n low asynchronously mid-BUSY, between clock edges → all outputs take their reset values immediately. After release, start → num = 8 on the next cycle.
